// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES-128 decryptor, one inverse round per clock
// Round keys arrive pre-expanded and are applied from round 10 down to the cipher key.
module aes_decrypt_iter (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic [127:0] round1_key,
  input  logic [127:0] round2_key,
  input  logic [127:0] round3_key,
  input  logic [127:0] round4_key,
  input  logic [127:0] round5_key,
  input  logic [127:0] round6_key,
  input  logic [127:0] round7_key,
  input  logic [127:0] round8_key,
  input  logic [127:0] round9_key,
  input  logic [127:0] round10_key,
  input  logic [127:0] cipher_text,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] plain_text,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] state;
  logic [3:0]   rcnt;
  logic [127:0] round_key;
  logic [127:0] sub_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine transform, then the field inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] a;
    logic [7:0] p;
    logic [7:0] r;
    a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  always_comb begin
    round_key = '0;
    case (rcnt)
      4'd1: round_key = round1_key;
      4'd2: round_key = round2_key;
      4'd3: round_key = round3_key;
      4'd4: round_key = round4_key;
      4'd5: round_key = round5_key;
      4'd6: round_key = round6_key;
      4'd7: round_key = round7_key;
      4'd8: round_key = round8_key;
      4'd9: round_key = round9_key;
      default: round_key = '0;
    endcase
  end

  assign sub_out = inv_shift_sub(state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm        <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      plain_text <= '0;
      state      <= '0;
      rcnt       <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= cipher_text ^ round10_key;
            rcnt     <= 4'd9;
            in_ready <= 1'b0;
            fsm      <= ROUND;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          state <= inv_mix(sub_out ^ round_key);
          rcnt  <= rcnt - 4'd1;
          if (rcnt == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          plain_text <= sub_out ^ key;
          out_valid  <= 1'b1;
          fsm        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - directed and round-trip bench for aes_decrypt_iter
// The reference side is a forward AES-128 model; decrypted output must equal the original plaintext.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] rk [0:10];
  logic [127:0] cipher_text = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plain_text;
  logic         out_valid;
  logic         out_ready = 1'b1;

  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           acc_count = 0;
  logic [127:0] exp_pt = '0;
  logic [127:0] sb [$];
  logic         prev_ov = 1'b0;
  logic [127:0] prev_pt = '0;
  logic [7:0]   sbox_t [0:255];

  always #5 clk = ~clk;

  aes_decrypt_iter dut (
    .clk(clk), .reset(reset), .key(rk[0]),
    .round1_key(rk[1]), .round2_key(rk[2]), .round3_key(rk[3]), .round4_key(rk[4]),
    .round5_key(rk[5]), .round6_key(rk[6]), .round7_key(rk[7]), .round8_key(rk[8]),
    .round9_key(rk[9]), .round10_key(rk[10]), .cipher_text(cipher_text),
    .in_valid(in_valid), .in_ready(in_ready), .plain_text(plain_text),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: wait expired, no event seen", name);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   b [16];
    logic [7:0]   n [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) n[w+4*c] = b[w+4*((c+w)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
          n[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          n[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          n[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          n[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = n[i];
      s = s ^ rk[r];
    end
    return s;
  endfunction

  task automatic set_vector(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    cipher_text = encrypt(pt);
    exp_pt = pt;
  endtask

  task automatic wait_accept(input string name);
    int start;
    int n;
    start = acc_count;
    n = 0;
    while (acc_count == start) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        timeout(name);
        break;
      end
    end
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        timeout(name);
        break;
      end
    end
  endtask

  task automatic send(input string name);
    in_valid = 1'b1;
    wait_accept(name);
    in_valid = 1'b0;
  endtask

  // Accept monitor: record what each accepted block must decrypt to.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset) sb.delete();
    else if (in_valid && in_ready) begin
      sb.push_back(exp_pt);
      acc_cyc = cyc;
      acc_count++;
    end
  end

  // Compare process: output values, latency, hold under backpressure, reset state.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
      chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
      chk("rst_plain_text", plain_text, 128'd0);
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL stale_output: got out_valid with %h, no block in flight", plain_text);
        end else begin
          chk("plain_text", plain_text, sb.pop_front());
          chk("latency", 128'(cyc - acc_cyc), 128'd10);
        end
      end
      if (out_valid && prev_ov) chk("hold_plain_text", plain_text, prev_pt);
      if (out_valid) chk("in_ready_busy", {127'b0, in_ready}, 128'd0);
    end
    prev_ov = out_valid;
    prev_pt = plain_text;
  end

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    int prev_acc;
    int start_cnt;
    for (int x = 0; x < 256; x++) begin : sb_init
      logic [7:0] v, inv;
      v = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(v, y[7:0]) == 8'h01) inv = y[7:0];
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    chk("model_sbox_53", {120'b0, sbox_t[8'h53]}, 128'hed);
    set_vector(C1_KEY, C1_PT);
    chk("model_c1_rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_c1_ct", cipher_text, C1_CT);

    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk) chk("in_ready_before_edge", {127'b0, in_ready}, 128'd0);
    @(negedge clk) chk("in_ready_after_release", {127'b0, in_ready}, 128'd1);

    send("c1_accept");
    wait_out("c1_out");
    chk("c1_plain_literal", plain_text, C1_PT);

    set_vector(B_KEY, B_PT);
    chk("model_b_rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_b_ct", cipher_text, B_CT);
    send("b_accept");
    wait_out("b_out");
    chk("b_plain_literal", plain_text, B_PT);

    // Backpressure on the C.1 vector.
    @(negedge clk);
    out_ready = 1'b0;
    set_vector(C1_KEY, C1_PT);
    send("bp_accept");
    wait_out("bp_out");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
    end
    chk("bp_plain_literal", plain_text, C1_PT);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", {127'b0, out_valid}, 128'd0);
    chk("bp_release_in_ready", {127'b0, in_ready}, 128'd1);

    // Back-to-back with in_valid held high, alternating B and C.1.
    @(negedge clk);
    start_cnt = acc_count;
    prev_acc = 0;
    set_vector(B_KEY, B_PT);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept("b2b_accept");
      if (k > 0) chk("b2b_interval", 128'(acc_cyc - prev_acc), 128'd12);
      prev_acc = acc_cyc;
      if (k == 3) in_valid = 1'b0;
      wait_out("b2b_out");
      chk("b2b_order", plain_text, (k % 2 == 0) ? B_PT : C1_PT);
      if (k < 3) begin
        if (k % 2 == 0) set_vector(C1_KEY, C1_PT);
        else set_vector(B_KEY, B_PT);
      end
    end
    repeat (15) @(negedge clk);
    chk("b2b_accept_count", 128'(acc_count - start_cnt), 128'd4);

    // Reset while a C.1 block is in its rounds.
    set_vector(C1_KEY, C1_PT);
    send("rst_accept");
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk) chk("rst_in_ready_hold", {127'b0, in_ready}, 128'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("rst_no_stale", {127'b0, out_valid}, 128'd0);
    end
    set_vector(B_KEY, B_PT);
    send("rst_b_accept");
    wait_out("rst_b_out");
    chk("rst_b_plain_literal", plain_text, B_PT);

    // Random round-trip through the forward model.
    for (int i = 0; i < 200; i++) begin
      set_vector({$urandom(), $urandom(), $urandom(), $urandom()},
                 {$urandom(), $urandom(), $urandom(), $urandom()});
      send("rt_accept");
      wait_out("rt_out");
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
